// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light conflict monitor: light codes,
// fault codes, monitor FSM encodings and small decode helpers.
package tlc_pkg;

    typedef enum logic [1:0] {
        RED     = 2'b00,
        YELLOW  = 2'b01,
        GREEN   = 2'b10,
        ILLEGAL = 2'b11
    } light_t;

    localparam logic [2:0] FC_NONE          = 3'd0;
    localparam logic [2:0] FC_CONFLICT      = 3'd1;
    localparam logic [2:0] FC_ILLEGAL_CODE  = 3'd2;
    localparam logic [2:0] FC_ILLEGAL_TRANS = 3'd3;
    localparam logic [2:0] FC_SHORT_YELLOW  = 3'd4;
    localparam logic [2:0] FC_SHORT_ALLRED  = 3'd5;

    typedef enum logic [1:0] {
        MON      = 2'b00,
        FAULT    = 2'b01,
        WAIT_CLR = 2'b10
    } mon_state_t;

    // One road may stay put or advance G->Y->R->G; anything else is illegal.
    function automatic logic step_legal(input logic [1:0] prev_code, input logic [1:0] cur_code);
        logic ok;
        if (prev_code == cur_code) begin
            ok = 1'b1;
        end else begin
            case ({prev_code, cur_code})
                {GREEN, YELLOW}: ok = 1'b1;
                {YELLOW, RED}:   ok = 1'b1;
                {RED, GREEN}:    ok = 1'b1;
                default:         ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Bit n of hits set means fault code n is present; the lowest code wins.
    function automatic logic [2:0] first_fault(input logic [5:1] hits);
        logic [2:0] code;
        if (hits[1]) begin
            code = FC_CONFLICT;
        end else if (hits[2]) begin
            code = FC_ILLEGAL_CODE;
        end else if (hits[3]) begin
            code = FC_ILLEGAL_TRANS;
        end else if (hits[4]) begin
            code = FC_SHORT_YELLOW;
        end else if (hits[5]) begin
            code = FC_SHORT_ALLRED;
        end else begin
            code = FC_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/tlc_conflict_monitor_if.sv
// Light-code bus between the controller, the safety monitor and the lamp drivers.
interface tlc_conflict_monitor_if;

    logic [1:0] hwy;
    logic [1:0] cntry;
    logic       ack;
    logic [1:0] safe_hwy;
    logic [1:0] safe_cntry;
    logic       fault;
    logic [2:0] fault_code;
    logic       flash;

    modport master (
        output hwy, cntry, ack,
        input  safe_hwy, safe_cntry, fault, fault_code, flash
    );

    modport slave (
        input  hwy, cntry, ack,
        output safe_hwy, safe_cntry, fault, fault_code, flash
    );

endinterface

// File: rtl/tlc_flash_div.sv
// Flash strobe divider: starts high on fault entry, toggles every FLASH_DIV
// cycles while enabled, and is held low whenever the monitor is not in fault.
module tlc_flash_div #(
    parameter int FLASH_DIV = 8
) (
    input  logic clk,
    input  logic clear_n,
    input  logic en,
    input  logic start,
    output logic flash
);

    localparam int DIV_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FLASH_DIV - 1);

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] cnt_s;
    logic             flash_r;
    logic             flash_s;

    // Next divider count and strobe level.
    always_comb begin
        cnt_s   = cnt_r;
        flash_s = flash_r;
        if (!en) begin
            cnt_s   = {DIV_W{1'b0}};
            flash_s = 1'b0;
        end else if (start) begin
            cnt_s   = {DIV_W{1'b0}};
            flash_s = 1'b1;
        end else if (cnt_r == DIV_LAST) begin
            cnt_s   = {DIV_W{1'b0}};
            flash_s = ~flash_r;
        end else begin
            cnt_s   = cnt_r + DIV_W'(1);
            flash_s = flash_r;
        end
    end

    // Divider state register.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            cnt_r   <= {DIV_W{1'b0}};
            flash_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_s;
            flash_r <= flash_s;
        end
    end

    assign flash = flash_r;

endmodule

// File: rtl/tlc_conflict_monitor.sv
// Safety monitor on the light-code bus: latches the first violation, forces
// all-red with a flash strobe, and releases after ack plus a clean all-red.
// Optional timing checks (short yellow / short all-red) under TLC_MON_TIMING_CHECK_EN.
module tlc_conflict_monitor
    import tlc_pkg::*;
#(
    parameter int MIN_YELLOW = 3,
    parameter int MIN_ALLRED = 1,
    parameter int CNT_W      = 4,
    parameter int FLASH_DIV  = 8
) (
    input  logic                   clk,
    input  logic                   clear_n,
    tlc_conflict_monitor_if.slave  bus
);

    mon_state_t state_r;
    mon_state_t state_s;

    logic [1:0] prev_hwy_r;
    logic [1:0] prev_cntry_r;
    logic       prev_vld_r;

    logic       hit_conflict_s;
    logic       hit_illegal_s;
    logic       hit_trans_s;
    logic       hit_short_y_s;
    logic       hit_short_ar_s;
    logic [2:0] code_s;
    logic       viol_s;
    logic       allred_ok_s;
    logic       in_allred_s;
    logic       enter_fault_s;

    logic [1:0] safe_hwy_r;
    logic [1:0] safe_cntry_r;
    logic       fault_r;
    logic [2:0] fault_code_r;
    logic [1:0] safe_hwy_s;
    logic [1:0] safe_cntry_s;
    logic       fault_s;
    logic [2:0] fault_code_s;

    assign in_allred_s    = (bus.hwy == RED) && (bus.cntry == RED);
    assign hit_conflict_s = (bus.hwy != RED) && (bus.cntry != RED);
    assign hit_illegal_s  = (bus.hwy == ILLEGAL) || (bus.cntry == ILLEGAL);
    assign hit_trans_s    = prev_vld_r &&
                            (!step_legal(prev_hwy_r, bus.hwy) || !step_legal(prev_cntry_r, bus.cntry));

`ifdef TLC_MON_TIMING_CHECK_EN
    localparam logic [CNT_W-1:0] DWELL_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_YELLOW_C = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MIN_ALLRED_C = CNT_W'(MIN_ALLRED);

    logic [CNT_W-1:0] dwell_r;
    logic [CNT_W-1:0] dwell_s;
    logic             pair_same_s;
    logic             prev_allred_s;

    assign pair_same_s   = prev_vld_r && (bus.hwy == prev_hwy_r) && (bus.cntry == prev_cntry_r);
    assign prev_allred_s = (prev_hwy_r == RED) && (prev_cntry_r == RED);

    // Dwell on the current (hwy, cntry) pair, saturating.
    always_comb begin
        dwell_s = dwell_r;
        if (!pair_same_s) begin
            dwell_s = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (dwell_r == DWELL_MAX) begin
            dwell_s = dwell_r;
        end else begin
            dwell_s = dwell_r + CNT_W'(1);
        end
    end

    // Dwell counter register.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            dwell_r <= {CNT_W{1'b0}};
        end else begin
            dwell_r <= dwell_s;
        end
    end

    assign hit_short_y_s  = prev_vld_r && (dwell_r < MIN_YELLOW_C) &&
                            (((prev_hwy_r == YELLOW) && (bus.hwy == RED)) ||
                             ((prev_cntry_r == YELLOW) && (bus.cntry == RED)));
    assign hit_short_ar_s = prev_vld_r && prev_allred_s && !in_allred_s && (dwell_r < MIN_ALLRED_C);
    assign allred_ok_s    = in_allred_s && (dwell_s >= MIN_ALLRED_C);
`else
    localparam int unused_cfg_p = MIN_YELLOW + MIN_ALLRED + CNT_W;

    assign hit_short_y_s  = 1'b0;
    assign hit_short_ar_s = 1'b0;
    assign allred_ok_s    = in_allred_s;
`endif

    assign code_s = first_fault({hit_short_ar_s, hit_short_y_s, hit_trans_s, hit_illegal_s, hit_conflict_s});
    assign viol_s = (code_s != FC_NONE);

    // Monitor state register.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_r <= MON;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; an unknown encoding is treated as a fault.
    always_comb begin
        state_s = state_r;
        case (state_r)
            MON: begin
                if (viol_s) begin
                    state_s = FAULT;
                end else begin
                    state_s = MON;
                end
            end
            FAULT: begin
                if (bus.ack) begin
                    state_s = WAIT_CLR;
                end else begin
                    state_s = FAULT;
                end
            end
            WAIT_CLR: begin
                if (allred_ok_s) begin
                    state_s = MON;
                end else begin
                    state_s = WAIT_CLR;
                end
            end
            default: state_s = FAULT;
        endcase
    end

    // Output next values: the offending sample is replaced by red at the same edge.
    always_comb begin
        safe_hwy_s    = RED;
        safe_cntry_s  = RED;
        fault_s       = fault_r;
        fault_code_s  = fault_code_r;
        enter_fault_s = 1'b0;
        case (state_r)
            MON: begin
                if (viol_s) begin
                    fault_s       = 1'b1;
                    fault_code_s  = code_s;
                    enter_fault_s = 1'b1;
                end else begin
                    safe_hwy_s   = bus.hwy;
                    safe_cntry_s = bus.cntry;
                end
            end
            FAULT: begin
                fault_s = 1'b1;
            end
            WAIT_CLR: begin
                if (allred_ok_s) begin
                    fault_s      = 1'b0;
                    fault_code_s = FC_NONE;
                end else begin
                    fault_s = 1'b1;
                end
            end
            default: begin
                fault_s       = 1'b1;
                enter_fault_s = 1'b1;
            end
        endcase
    end

    // Registered lamp outputs, fault latch and previous-sample history.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            safe_hwy_r   <= RED;
            safe_cntry_r <= RED;
            fault_r      <= 1'b0;
            fault_code_r <= FC_NONE;
            prev_hwy_r   <= RED;
            prev_cntry_r <= RED;
            prev_vld_r   <= 1'b0;
        end else begin
            safe_hwy_r   <= safe_hwy_s;
            safe_cntry_r <= safe_cntry_s;
            fault_r      <= fault_s;
            fault_code_r <= fault_code_s;
            prev_hwy_r   <= bus.hwy;
            prev_cntry_r <= bus.cntry;
            prev_vld_r   <= !((state_r == WAIT_CLR) && (state_s == MON));
        end
    end

    tlc_flash_div #(
        .FLASH_DIV (FLASH_DIV)
    ) u_flash_div (
        .clk     (clk),
        .clear_n (clear_n),
        .en      (state_s != MON),
        .start   (enter_fault_s),
        .flash   (bus.flash)
    );

    assign bus.safe_hwy   = safe_hwy_r;
    assign bus.safe_cntry = safe_cntry_r;
    assign bus.fault      = fault_r;
    assign bus.fault_code = fault_code_r;

endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// Directed, table-driven bench for tlc_conflict_monitor with hand-written
// sequences for flash timing, code latching, recovery and asynchronous clear.
module tb_tlc_conflict_monitor;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] G = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic clk = 1'b0;
    logic clear_n = 1'b0;

    tlc_conflict_monitor_if bus_if();

    tlc_conflict_monitor #(
        .MIN_YELLOW (3),
        .MIN_ALLRED (1),
        .CNT_W      (4),
        .FLASH_DIV  (8)
    ) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] h;
        logic [1:0] c;
        logic       a;
        logic [1:0] sh;
        logic [1:0] sc;
        logic       f;
        logic [2:0] code;
        logic       fl;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] h, input logic [1:0] c, input logic a,
                       input logic [1:0] sh, input logic [1:0] sc, input logic f,
                       input logic [2:0] code, input logic fl);
        vec_t v;
        v.h = h; v.c = c; v.a = a; v.sh = sh; v.sc = sc; v.f = f; v.code = code; v.fl = fl;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [1:0] sh, input logic [1:0] sc,
                         input logic f, input logic [2:0] code, input logic fl);
        logic [8:0] act;
        logic [8:0] exp;
        act = {bus_if.safe_hwy, bus_if.safe_cntry, bus_if.fault, bus_if.fault_code, bus_if.flash};
        exp = {sh, sc, f, code, fl};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got safe=%b/%b fault=%b code=%0d flash=%b, want safe=%b/%b fault=%b code=%0d flash=%b",
                     name, act[8:7], act[6:5], act[4], act[3:1], act[0],
                     sh, sc, f, code, fl);
        end
    endtask

    task automatic drive(input logic [1:0] h, input logic [1:0] c, input logic a);
        bus_if.hwy   = h;
        bus_if.cntry = c;
        bus_if.ack   = a;
    endtask

    task automatic step(input logic [1:0] h, input logic [1:0] c, input logic a);
        drive(h, c, a);
        @(posedge clk);
        #1;
    endtask

    // Ack with all-red, then one more all-red: back in MON from FAULT or MON.
    task automatic recover(input string name);
        step(R, R, 1'b1);
        step(R, R, 1'b0);
        check(name, R, R, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        drive(R, R, 1'b0);
        clear_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", R, R, 1'b0, 3'd0, 1'b0);
        clear_n = 1'b1;

        // Legal cycle, conflict with simultaneous ack, ack/wait-clear, re-entry.
        add(G, R, 1'b0,  G, R, 1'b0, 3'd0, 1'b0);
        add(Y, R, 1'b0,  Y, R, 1'b0, 3'd0, 1'b0);
        add(Y, R, 1'b0,  Y, R, 1'b0, 3'd0, 1'b0);
        add(Y, R, 1'b0,  Y, R, 1'b0, 3'd0, 1'b0);
        add(R, R, 1'b0,  R, R, 1'b0, 3'd0, 1'b0);
        add(R, G, 1'b0,  R, G, 1'b0, 3'd0, 1'b0);
        add(R, Y, 1'b0,  R, Y, 1'b0, 3'd0, 1'b0);
        add(R, Y, 1'b0,  R, Y, 1'b0, 3'd0, 1'b0);
        add(R, Y, 1'b0,  R, Y, 1'b0, 3'd0, 1'b0);
        add(R, R, 1'b0,  R, R, 1'b0, 3'd0, 1'b0);
        add(G, R, 1'b0,  G, R, 1'b0, 3'd0, 1'b0);
        add(G, G, 1'b1,  R, R, 1'b1, 3'd1, 1'b1);
        add(G, G, 1'b0,  R, R, 1'b1, 3'd1, 1'b1);
        add(G, R, 1'b1,  R, R, 1'b1, 3'd1, 1'b1);
        add(G, R, 1'b1,  R, R, 1'b1, 3'd1, 1'b1);
        add(G, R, 1'b0,  R, R, 1'b1, 3'd1, 1'b1);
        add(G, R, 1'b0,  R, R, 1'b1, 3'd1, 1'b1);
        add(G, R, 1'b0,  R, R, 1'b1, 3'd1, 1'b1);
        add(R, R, 1'b0,  R, R, 1'b0, 3'd0, 1'b0);
        add(Y, R, 1'b0,  Y, R, 1'b0, 3'd0, 1'b0);
        add(Y, R, 1'b0,  Y, R, 1'b0, 3'd0, 1'b0);
        add(Y, R, 1'b0,  Y, R, 1'b0, 3'd0, 1'b0);
        add(R, R, 1'b0,  R, R, 1'b0, 3'd0, 1'b0);
        add(G, R, 1'b0,  G, R, 1'b0, 3'd0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].h, vecs[i].c, vecs[i].a);
            check($sformatf("vec%0d", i), vecs[i].sh, vecs[i].sc, vecs[i].f, vecs[i].code, vecs[i].fl);
        end

        // Flash strobe: high on entry, toggles every 8 cycles.
        step(G, G, 1'b0);
        check("flash_entry", R, R, 1'b1, 3'd1, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            step(G, G, 1'b0);
            check($sformatf("flash_%0d", i), R, R, 1'b1, 3'd1, ((i % 16) < 8) ? 1'b1 : 1'b0);
        end
        recover("recover_conflict");

        // Illegal transition G->R, then a later conflict must not replace the code.
        step(G, R, 1'b0);
        check("pre_trans", G, R, 1'b0, 3'd0, 1'b0);
        step(R, R, 1'b0);
        check("illegal_trans", R, R, 1'b1, 3'd3, 1'b1);
        step(G, G, 1'b0);
        check("code_kept", R, R, 1'b1, 3'd3, 1'b1);
        recover("recover_trans");

        // Yellow held only two samples.
        step(G, R, 1'b0);
        step(Y, R, 1'b0);
        step(Y, R, 1'b0);
        step(R, R, 1'b0);
`ifdef TLC_MON_TIMING_CHECK_EN
        check("short_yellow", R, R, 1'b1, 3'd4, 1'b1);
`else
        check("short_yellow", R, R, 1'b0, 3'd0, 1'b0);
`endif
        recover("recover_yellow");

        // Illegal code beats the illegal transition; conflict beats illegal code.
        step(G, R, 1'b0);
        step(X, R, 1'b0);
        check("illegal_code", R, R, 1'b1, 3'd2, 1'b1);
        recover("recover_code");
        step(X, G, 1'b0);
        check("priority", R, R, 1'b1, 3'd1, 1'b1);
        recover("recover_priority");

        // Asynchronous clear in the middle of a fault.
        step(G, R, 1'b0);
        step(G, G, 1'b0);
        check("pre_clear", R, R, 1'b1, 3'd1, 1'b1);
        #2;
        clear_n = 1'b0;
        #1;
        check("async_clear", R, R, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        clear_n = 1'b1;
        step(G, R, 1'b0);
        check("after_clear", G, R, 1'b0, 3'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tlc_conflict_monitor.md
# tlc_conflict_monitor

Independent safety monitor on the light-code bus between the traffic light controller and the lamp drivers. It samples the highway and country light codes every clock and checks for conflicting greens, illegal codes, illegal colour sequences and short yellow/all-red intervals. On the first violation it latches a fault code and forces both roads to red with a flash strobe. It returns to monitoring only after an operator acknowledge and a clean all-red interval.

## Interface
- MIN_YELLOW, 3: minimum consecutive cycles a yellow must be held before red
- MIN_ALLRED, 1: minimum consecutive cycles of red/red before either road leaves red
- CNT_W, 4: dwell counter width; must satisfy 2^CNT_W-1 >= max(MIN_YELLOW, MIN_ALLRED)
- FLASH_DIV, 8: cycles per flash strobe half-period in fault
- clk  in  1  system clock, all logic on rising edge
- clear_n  in  1  asynchronous active-low reset
- hwy  in  2  highway light code from controller (00 red, 01 yellow, 10 green, 11 illegal)
- cntry  in  2  country light code from controller, same encoding
- ack  in  1  operator fault acknowledge, level-sampled
- safe_hwy  out  2  highway code to lamp drivers
- safe_cntry  out  2  country code to lamp drivers
- fault  out  1  fault latched
- fault_code  out  3  cause of latched fault
- flash  out  1  lamp flash strobe, toggles only in fault

## Operation
- Fault codes: 0 none, 1 conflict (both non-red), 2 illegal code 11 on either road, 3 illegal transition, 4 short yellow, 5 short all-red. When several are present in one sample, the lowest non-zero code wins.
- Legal per-road transitions: no change, G->Y, Y->R, R->G. Any other change gives code 3.
- prev_vld: reset 0, set after the first sample. Transition and timing checks are skipped while prev_vld=0. Codes 1/2 are always checked.
- Dwell counter: counts consecutive samples of the current (hwy,cntry) pair. It reloads to 1 when the pair changes and saturates at 2^CNT_W-1.
  - Y->R with dwell < MIN_YELLOW gives code 4.
  - Leaving red/red to any non-red pair with dwell < MIN_ALLRED gives code 5.
- FSM states:
  - MON: monitoring. A violation moves to FAULT.
  - FAULT: ack=1 moves to WAIT_CLR. Further violations are ignored and the first fault_code is kept.
  - WAIT_CLR: moves to MON once the inputs have been red/red for MIN_ALLRED consecutive samples. Violations in this state only restart the red/red count.
  - Entering MON from WAIT_CLR clears fault, sets fault_code=0 and reloads prev_vld=0.
- Outputs by state:
  - MON: safe_* = registered copy of the inputs.
  - FAULT and WAIT_CLR: safe_* = 00/00. flash toggles every FLASH_DIV cycles, starting at 1 on fault entry.
  - MON: flash = 0.

## Timing
- Reset values: state MON, safe_hwy=00, safe_cntry=00, fault=0, fault_code=0, flash=0, prev_vld=0, dwell=0.
- Pass-through latency: 1 cycle. Inputs sampled at edge k appear on safe_* after edge k.
- Detection latency: a violation sampled at edge k sets fault/fault_code and forces safe_*=red at that same edge. The offending code never reaches safe_*.
- Violation and ack in the same sample while in MON: the violation wins and ack is ignored.
- ack held from FAULT into WAIT_CLR has no further effect.
- clear_n asserted mid-fault: all state and outputs return to reset values immediately, asynchronously.

## Configuration
- TLC_MON_TIMING_CHECK_EN
  - Defined: codes 4 and 5 are checked and the dwell counter is built.
  - Undefined: no dwell counter, codes 4/5 never raised, and WAIT_CLR exits after a single red/red sample. MIN_YELLOW, MIN_ALLRED and CNT_W are unused.

## Structure
- Shared package tlc_pkg holds:
  - light codes RED/YELLOW/GREEN
  - fault code constants
  - monitor FSM state encodings MON/FAULT/WAIT_CLR
- Sub-module tlc_flash_div: enable-gated FLASH_DIV divider producing the flash toggle, cleared whenever the FSM is in MON.

## Test plan
- Legal cycle G/R, Y/R x3, R/R x1, R/G, R/Y x3, R/R, G/R with defaults -> fault=0 throughout; safe_* track inputs with 1-cycle delay.
- Inject G/G mid-sequence -> that edge: fault=1, fault_code=1, safe_*=00/00; flash toggles every 8 cycles.
- Y/R held 2 cycles then R/R -> fault_code=4. With TLC_MON_TIMING_CHECK_EN undefined, same stimulus -> fault=0.
- G/R direct to R/R -> fault_code=3. Then a later G/G during FAULT -> fault_code stays 3.
- In FAULT, pulse ack with inputs G/R for 5 cycles, then R/R -> stays in WAIT_CLR until the first R/R sample, then MON on the next edge with fault=0, fault_code=0.
- Assert clear_n low while flash=1 in FAULT -> all outputs 0 immediately. First sample after release is G/R -> fault=0.
